// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator ALU sequencer.
// Optional saturation build: define CALC_SAT_EN.
package calc_pkg;

   localparam int DATA_W = 4;

   localparam logic [2:0] OP_ADD_AB = 3'b000;
   localparam logic [2:0] OP_ADD_BA = 3'b100;
   localparam logic [2:0] OP_SUB_AB = 3'b001;
   localparam logic [2:0] OP_SUB_BA = 3'b101;
   localparam logic [2:0] OP_ABS_B  = 3'b010;
   localparam logic [2:0] OP_ABS_A  = 3'b110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      HOLD  = 2'd2,
      ERROR = 2'd3
   } state_t;

   typedef struct packed {
      logic [2:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              use_acc;
   } cmd_t;

   // Sign of the true result of an overflowing op: abs is always
   // positive, add overflow keeps the operand sign, sub the minuend sign.
   function automatic logic sat_neg(input logic [2:0] op,
                                    input logic a_msb,
                                    input logic b_msb);
      logic neg;
      neg = 1'b0;
      if (op[1])
         neg = 1'b0;
      else if (op[2])
         neg = b_msb;
      else
         neg = a_msb;
      return neg;
   endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command queue: power-of-two depth, in-order, synchronous flush.
// Pointers carry an extra wrap bit to tell full from empty.
module calc_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);
   assign dout  = mem[rptr[AW-1:0]];

   // Pointer update; flush empties the queue in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full)
            wptr <= wptr + ONE;
         if (pop && !empty)
            rptr <= rptr + ONE;
      end
   end

   // Storage write; contents need no reset since pointers gate reads.
   always_ff @(posedge clk) begin
      if (push && !full && !flush)
         mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/calc_alu_sequencer.sv
// Queues calculator commands and issues them one at a time to the ALU.
// CALC_SAT_EN: saturate overflowing results instead of entering ERROR.
module calc_alu_sequencer #(
   parameter int DATA_W     = calc_pkg::DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLOCK_50,
   input  logic              RST_N,
   input  logic              clr,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic              cmd_use_acc,
   output logic [2:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_r,
   input  logic              alu_ovf,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_ovf,
   output logic [DATA_W-1:0] acc,
   output logic              err,
   output logic              busy
);

   import calc_pkg::*;

   localparam int CMD_W = 3 + 2 * DATA_W + 1;

   state_t            state;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [CMD_W-1:0]  head;
   logic [2:0]        head_op;
   logic [DATA_W-1:0] head_a;
   logic [DATA_W-1:0] head_b;
   logic              head_use_acc;
   logic [DATA_W-1:0] result;

   assign cmd_ready = RST_N & ~fifo_full;
   assign push      = cmd_valid & cmd_ready & ~clr;
   assign pop       = (state == IDLE) & ~fifo_empty & ~err & ~clr;
   assign busy      = (state != IDLE) | ~fifo_empty;

   assign {head_op, head_a, head_b, head_use_acc} = head;

   calc_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk   (CLOCK_50),
      .rst_n (RST_N),
      .flush (clr),
      .push  (push),
      .pop   (pop),
      .din   ({cmd_op, cmd_a, cmd_b, cmd_use_acc}),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef CALC_SAT_EN
   logic neg;
   assign neg = sat_neg(alu_op, alu_a[DATA_W-1], alu_b[DATA_W-1]);
   assign result = !alu_ovf ? alu_r :
                   neg      ? {1'b1, {(DATA_W-1){1'b0}}} :
                              {1'b0, {(DATA_W-1){1'b1}}};
`else
   assign result = alu_r;
`endif

   // Issue / capture / handshake sequencer with registered outputs.
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         alu_op    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_ovf   <= 1'b0;
         acc       <= '0;
         err       <= 1'b0;
      end else if (clr) begin
         state     <= IDLE;
         res_valid <= 1'b0;
         acc       <= '0;
         err       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  alu_op <= head_op;
                  alu_a  <= head_use_acc ? acc : head_a;
                  alu_b  <= head_b;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               res_data  <= result;
               res_ovf   <= alu_ovf;
               res_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
`ifdef CALC_SAT_EN
                  acc   <= res_data;
                  state <= IDLE;
`else
                  if (res_ovf) begin
                     err   <= 1'b1;
                     state <= ERROR;
                  end else begin
                     acc   <= res_data;
                     state <= IDLE;
                  end
`endif
               end
            end
            ERROR: begin
               err <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
